// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: size codes, the
// pending-load record, and the lane/extension helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;

  // Offsets are held at the 64-bit width so one record serves both word sizes.
  typedef struct packed {
    logic [2:0] off;
    logic [1:0] size;
    logic       unsigned_load;
  } pending_t;

  localparam int PENDING_W = $bits(pending_t);

  function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] mask;
    case (size)
      SZ_BYTE: mask = 8'h01;
      SZ_HALF: mask = 8'h03;
      SZ_WORD: mask = 8'h0f;
      default: mask = 8'hff;
    endcase
    return mask << off;
  endfunction

  function automatic logic [63:0] replicate(input logic [63:0] data, input logic [1:0] size);
    logic [63:0] r;
    case (size)
      SZ_BYTE: r = {8{data[7:0]}};
      SZ_HALF: r = {4{data[15:0]}};
      SZ_WORD: r = {2{data[31:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] data, input logic [1:0] size,
                                         input logic unsigned_load);
    logic [63:0] r;
    case (size)
      SZ_BYTE: r = {{56{~unsigned_load & data[7]}}, data[7:0]};
      SZ_HALF: r = {{48{~unsigned_load & data[15]}}, data[15:0]};
      SZ_WORD: r = {{32{~unsigned_load & data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_pending_fifo.sv
// Small synchronous FIFO holding the shape of each outstanding load so the
// in-order read responses can be sliced and extended on return.
module lsu_pending_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = DEPTH;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so wrap is free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/memory_unit_lsu.sv
// Load/store unit between Execute/Writeback and the data cache port: sub-word
// lanes, misalignment detection and in-order tracking of outstanding loads.
module memory_unit_lsu
  import lsu_pkg::*;
#(
  parameter int CORE          = 0,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_BITS  = 20,
  parameter int PENDING_DEPTH = 4,
  localparam int BE_BITS      = DATA_WIDTH / 8,
  localparam int OFF_BITS     = $clog2(BE_BITS),
  localparam int WORD_BITS    = ADDRESS_BITS - OFF_BITS,
  localparam int CNT_W        = $clog2(PENDING_DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    store,
  input  logic [1:0]              size,
  input  logic                    unsigned_load,
  input  logic [ADDRESS_BITS-1:0] address,
  input  logic [DATA_WIDTH-1:0]   store_data,
  output logic                    stall,
  output logic                    misaligned,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic [ADDRESS_BITS-1:0] data_addr,
  output logic                    valid,
  output logic                    protocol_error,
  input  logic                    d_mem_ready,
  input  logic                    d_mem_valid,
  input  logic [DATA_WIDTH-1:0]   d_mem_out_data,
  input  logic [WORD_BITS-1:0]    d_mem_out_addr,
  output logic [WORD_BITS-1:0]    d_mem_address,
  output logic [DATA_WIDTH-1:0]   d_mem_in_data,
  output logic [BE_BITS-1:0]      d_mem_byte_en,
  output logic                    d_mem_read,
  output logic                    d_mem_write,
  input  logic                    report
);

  localparam logic [1:0] MAX_SIZE = 2'(OFF_BITS);

  logic [2:0]       off;
  logic [2:0]       align_mask;
  logic             req;
  logic             accepted;
  logic             full;
  logic             empty;
  logic             pop;
  logic [CNT_W-1:0] fifo_count;
  logic [PENDING_W-1:0] fifo_dout;
  pending_t         head;

  assign off = 3'(address[OFF_BITS-1:0]);

  always_comb begin
    case (size)
      SZ_BYTE: align_mask = 3'b000;
      SZ_HALF: align_mask = 3'b001;
      SZ_WORD: align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  // Handshake: a request is taken on a clock edge where its strobe and
  // d_mem_ready are both high; until then stall holds the pipeline, which keeps
  // its inputs steady. Full blocks reads even on a popping cycle, so the read
  // strobe never depends on d_mem_valid.
  assign req         = load | store;
  assign misaligned  = req & ((|(off & align_mask)) | (size > MAX_SIZE));
  assign d_mem_read  = load & ~misaligned & ~full;
  assign d_mem_write = store & ~misaligned;
  assign accepted    = (d_mem_read | d_mem_write) & d_mem_ready;
  assign stall       = req & ~misaligned & ~accepted;

  assign d_mem_address = address[ADDRESS_BITS-1:OFF_BITS];
  assign d_mem_byte_en = BE_BITS'(byte_en(size, off));
  assign d_mem_in_data = DATA_WIDTH'(replicate(64'(store_data), size));

  assign pop  = d_mem_valid & ~empty;
  assign head = pending_t'(fifo_dout);

  lsu_pending_fifo #(
    .DEPTH (PENDING_DEPTH),
    .WIDTH (PENDING_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accepted & load),
    .pop   (pop),
    .din   ({off, size, unsigned_load}),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid          <= 1'b0;
      load_data      <= '0;
      data_addr      <= '0;
      protocol_error <= 1'b0;
    end else begin
      valid <= pop;
      if (pop) begin
        load_data <= DATA_WIDTH'(extend(64'(d_mem_out_data) >> {head.off, 3'b000},
                                        head.size, head.unsigned_load));
        data_addr <= {d_mem_out_addr, head.off[OFF_BITS-1:0]};
      end
      // A response with nothing outstanding is dropped and flagged until reset.
      if (d_mem_valid & empty) protocol_error <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (report)
      $display("[lsu%0d] ld=%b st=%b sz=%0d addr=%h stall=%b mis=%b cnt=%0d rsp=%b rdata=%h",
               CORE, load, store, size, address, stall, misaligned, fifo_count,
               d_mem_valid, d_mem_out_data);
  end
`endif

endmodule

// File: tb/tb_memory_unit_lsu.sv
// Bench for memory_unit_lsu: directed corner cases plus randomized traffic
// against a byte-array reference model and a behavioural cache.
module tb_memory_unit_lsu;

  localparam int DW = 32;
  localparam int AB = 20;
  localparam int BE = DW / 8;
  localparam int WB = AB - 2;
  localparam int EW = AB + DW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load, store, unsigned_load, report;
  logic [1:0]    size;
  logic [AB-1:0] address;
  logic [DW-1:0] store_data;
  logic          stall, misaligned, valid, protocol_error;
  logic [DW-1:0] load_data;
  logic [AB-1:0] data_addr;
  logic          d_mem_ready, d_mem_valid, d_mem_read, d_mem_write;
  logic [DW-1:0] d_mem_out_data, d_mem_in_data;
  logic [WB-1:0] d_mem_out_addr, d_mem_address;
  logic [BE-1:0] d_mem_byte_en;

  memory_unit_lsu #(.CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .PENDING_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .load(load), .store(store), .size(size),
    .unsigned_load(unsigned_load), .address(address), .store_data(store_data),
    .stall(stall), .misaligned(misaligned), .load_data(load_data), .data_addr(data_addr),
    .valid(valid), .protocol_error(protocol_error), .d_mem_ready(d_mem_ready),
    .d_mem_valid(d_mem_valid), .d_mem_out_data(d_mem_out_data),
    .d_mem_out_addr(d_mem_out_addr), .d_mem_address(d_mem_address),
    .d_mem_in_data(d_mem_in_data), .d_mem_byte_en(d_mem_byte_en),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .report(report)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0] ref_mem [1024];
  logic [7:0] cache_mem [1024];

  typedef struct { logic [WB-1:0] waddr; logic [DW-1:0] data; } rd_t;
  rd_t cache_rq[$];
  int  ready_mode = 1;    // 0 low, 1 high, 2 random
  bit  resp_hold  = 1'b1;
  int  resp_pct   = 100;
  bit  spurious   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: little-endian bytes, then wrap by 2^(8n) for negative values.
  function automatic logic [DW-1:0] model_load(input int a, input int sz, input bit uns);
    logic [63:0] v = 0;
    int n = 1 << sz;
    for (int i = 0; i < n; i++) v = v + (64'(ref_mem[a + i]) << (8 * i));
    if (!uns && ref_mem[a + n - 1][7]) v = v - (64'd1 << (8 * n));
    return DW'(v);
  endfunction

  function automatic bit model_misaligned(input int a, input int sz);
    return (sz > 2) || ((a % (1 << sz)) != 0);
  endfunction

  task automatic ref_store(input int a, input int sz, input logic [DW-1:0] sd);
    for (int i = 0; i < (1 << sz); i++) ref_mem[a + i] = sd[8 * i +: 8];
  endtask

  // ---------------- behavioural cache ----------------
  initial begin
    bit rd_fire, wr_fire, resp_fire, last_spur;
    logic [WB-1:0] c_addr;
    logic [DW-1:0] c_data;
    logic [BE-1:0] c_be;
    rd_t r;
    last_spur = 1'b0;
    d_mem_ready = 1'b0; d_mem_valid = 1'b0; d_mem_out_data = '0; d_mem_out_addr = '0;
    forever begin
      @(negedge clock);
      rd_fire = d_mem_read & d_mem_ready;
      wr_fire = d_mem_write & d_mem_ready;
      resp_fire = d_mem_valid;
      c_addr = d_mem_address; c_data = d_mem_in_data; c_be = d_mem_byte_en;
      @(posedge clock); #1;
      if (!reset) begin
        cache_rq.delete();
        d_mem_valid = 1'b0;
        last_spur = 1'b0;
      end else begin
        if (wr_fire)
          for (int i = 0; i < BE; i++)
            if (c_be[i]) cache_mem[(int'(c_addr) * BE + i) % 1024] = c_data[8 * i +: 8];
        if (rd_fire) begin
          r.waddr = c_addr;
          for (int i = 0; i < BE; i++) r.data[8 * i +: 8] = cache_mem[(int'(c_addr) * BE + i) % 1024];
          cache_rq.push_back(r);
        end
        if (resp_fire && !last_spur && cache_rq.size() > 0) void'(cache_rq.pop_front());
        case (ready_mode)
          0: d_mem_ready = 1'b0;
          1: d_mem_ready = 1'b1;
          default: d_mem_ready = ($urandom_range(0, 3) != 0);
        endcase
        last_spur = 1'b0;
        if (spurious) begin
          spurious = 1'b0; last_spur = 1'b1;
          d_mem_valid = 1'b1; d_mem_out_data = $urandom; d_mem_out_addr = WB'($urandom);
        end else if (!resp_hold && cache_rq.size() > 0 && $urandom_range(1, 100) <= resp_pct) begin
          d_mem_valid = 1'b1; d_mem_out_data = cache_rq[0].data; d_mem_out_addr = cache_rq[0].waddr;
        end else begin
          d_mem_valid = 1'b0; d_mem_out_data = $urandom;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (reset && valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got data=%h addr=%h with no load outstanding", load_data, data_addr);
      end else begin
        e = exp_q.pop_front();
        if (load_data !== e[DW-1:0] || data_addr !== e[EW-1:DW]) begin
          errors++;
          $display("FAIL load_resp: got data=%h addr=%h expected data=%h addr=%h",
                   load_data, data_addr, e[DW-1:0], e[EW-1:DW]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic present(input bit is_load, input int sz, input bit uns, input int a,
                         input logic [DW-1:0] sd);
    load = is_load; store = !is_load; size = 2'(sz); unsigned_load = uns;
    address = AB'(a); store_data = sd;
  endtask

  task automatic idle();
    load = 1'b0; store = 1'b0;
  endtask

  // Holds a request until taken, then records its effect in the model.
  task automatic do_op(input bit is_load, input int sz, input bit uns, input int a,
                       input logic [DW-1:0] sd, input bit use_given, input logic [DW-1:0] given);
    int n = 0;
    bit ok = 1'b0;
    present(is_load, sz, uns, a, sd);
    while (!ok) begin
      @(negedge clock);
      if (!stall) ok = 1'b1;
      else if (++n > 300) begin
        checks++; errors++;
        $display("FAIL issue_timeout: request at %h still stalled after %0d cycles", a, n);
        break;
      end
    end
    if (ok) chk("aligned_not_misaligned", 64'(misaligned), 64'd0);
    @(posedge clock); #1;
    if (ok) begin
      if (is_load) exp_q.push_back({AB'(a), use_given ? given : model_load(a, sz, uns)});
      else ref_store(a, sz, sd);
    end
    idle();
  endtask

  task automatic do_bad(input bit is_load, input int sz, input int a);
    present(is_load, sz, 1'b0, a, DW'($urandom));
    @(negedge clock);
    chk("bad_misaligned", 64'(misaligned), 64'd1);
    chk("bad_no_read", 64'(d_mem_read), 64'd0);
    chk("bad_no_write", 64'(d_mem_write), 64'd0);
    chk("bad_no_stall", 64'(stall), 64'd0);
    @(posedge clock); #1;
    idle();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses still outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a, sz;
    bit is_ld;
    report = 1'b0;
    idle(); size = '0; unsigned_load = 1'b0; address = '0; store_data = '0;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 8'($urandom);
      cache_mem[i] = ref_mem[i];
    end
    ref_mem[256] = 8'h01; ref_mem[257] = 8'h80; ref_mem[258] = 8'he0; ref_mem[259] = 8'hf0;
    for (int i = 256; i < 260; i++) cache_mem[i] = ref_mem[i];

    repeat (3) @(negedge clock);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_load_data", 64'(load_data), 64'd0);
    chk("rst_data_addr", 64'(data_addr), 64'd0);
    chk("rst_protocol_error", 64'(protocol_error), 64'd0);
    chk("rst_read", 64'(d_mem_read), 64'd0);
    reset = 1'b1;
    ready_mode = 1; resp_hold = 1'b1; resp_pct = 100;
    @(posedge clock); #1;

    // Full FIFO: four loads held, the fifth stalls even while a pop occurs.
    do_op(1, 0, 0, 'h100, '0, 1, 32'h0000_0001);
    do_op(1, 0, 0, 'h101, '0, 1, 32'hffff_ff80);
    do_op(1, 0, 1, 'h103, '0, 1, 32'h0000_00f0);
    do_op(1, 1, 0, 'h102, '0, 1, 32'hffff_f0e0);
    present(1, 2, 0, 'h100, '0);
    @(negedge clock);
    chk("full_stall", 64'(stall), 64'd1);
    chk("full_no_read", 64'(d_mem_read), 64'd0);
    resp_hold = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("full_pop_stall", 64'(stall), 64'd1);
    chk("full_pop_no_read", 64'(d_mem_read), 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("after_pop_no_stall", 64'(stall), 64'd0);
    chk("after_pop_read", 64'(d_mem_read), 64'd1);
    @(posedge clock); #1;
    exp_q.push_back({AB'('h100), 32'hf0e0_8001});
    idle();
    drain();

    // Store lanes.
    present(0, 1, 0, 'h106, 32'h0000_abcd);
    @(negedge clock);
    chk("sh_address", 64'(d_mem_address), 64'h41);
    chk("sh_byte_en", 64'(d_mem_byte_en), 64'b1100);
    chk("sh_in_data", 64'(d_mem_in_data), 64'habcd_abcd);
    chk("sh_write", 64'(d_mem_write), 64'd1);
    @(posedge clock); #1;
    ref_store('h106, 1, 32'h0000_abcd);
    present(0, 0, 0, 'h105, 32'h0000_007f);
    @(negedge clock);
    chk("sb_byte_en", 64'(d_mem_byte_en), 64'b0010);
    chk("sb_in_data", 64'(d_mem_in_data), 64'h7f7f_7f7f);
    @(posedge clock); #1;
    ref_store('h105, 0, 32'h0000_007f);
    idle();
    do_op(1, 2, 0, 'h104, '0, 0, '0);
    drain();

    // Misalignment.
    do_bad(1, 2, 'h102);
    do_bad(1, 1, 'h103);
    do_bad(1, 3, 'h100);

    // Back-pressure: three refused cycles then one accepted load.
    @(negedge clock); ready_mode = 0;
    @(posedge clock); #1;
    present(1, 0, 1, 'h101, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_stall", 64'(stall), 64'd1);
    end
    ready_mode = 1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("bp_release", 64'(stall), 64'd0);
    @(posedge clock); #1;
    exp_q.push_back({AB'('h101), 32'h0000_0080});
    idle();
    drain();

    // Randomized traffic.
    @(negedge clock); ready_mode = 2; resp_pct = 60;
    @(posedge clock); #1;
    for (int k = 0; k < 300; k++) begin
      is_ld = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) begin
        sz = $urandom_range(0, 3);
        a = $urandom_range(0, 1023);
      end else begin
        sz = $urandom_range(0, 2);
        a = $urandom_range(0, 1023) & ~((1 << sz) - 1);
      end
      if (model_misaligned(a, sz)) do_bad(is_ld, sz, a);
      else do_op(is_ld, sz, $urandom_range(0, 1), a, DW'($urandom), 0, '0);
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
    drain();
    @(negedge clock);
    chk("no_protocol_error", 64'(protocol_error), 64'd0);

    // Spurious response.
    spurious = 1'b1;
    repeat (2) @(negedge clock);
    chk("spur_protocol_error", 64'(protocol_error), 64'd1);
    chk("spur_valid", 64'(valid), 64'd0);
    @(negedge clock);
    chk("spur_sticky", 64'(protocol_error), 64'd1);

    // Asynchronous reset with loads outstanding.
    resp_hold = 1'b1; ready_mode = 1;
    @(posedge clock); #1;
    do_op(1, 2, 0, 'h200, '0, 0, '0);
    do_op(1, 0, 0, 'h203, '0, 0, '0);
    @(negedge clock); #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("amid_count", 64'(dut.u_fifo.count), 64'd0);
    chk("amid_valid", 64'(valid), 64'd0);
    chk("amid_load_data", 64'(load_data), 64'd0);
    chk("amid_data_addr", 64'(data_addr), 64'd0);
    chk("amid_protocol_error", 64'(protocol_error), 64'd0);
    repeat (2) @(negedge clock);
    resp_hold = 1'b0; resp_pct = 100; ready_mode = 2;
    reset = 1'b1;
    @(posedge clock); #1;
    for (int k = 0; k < 6; k++) do_op(1, 2, $urandom_range(0, 1), 4 * $urandom_range(0, 255), '0, 0, '0);
    drain();
    repeat (3) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
